// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: op codes, FSM states,
// and the op-code legality helpers used by the arbiter and the ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int NREQ      = 2;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SUB  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR,
            ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SUB: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the arbiter.
// Index i of every per-port vector belongs to requester i.
interface alu_arbiter_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    localparam int NREQ = alu_pkg::NREQ;

    logic [NREQ-1:0]            reqValid;
    logic [NREQ-1:0]            reqReady;
    logic [NREQ-1:0][WIDTH-1:0] reqA;
    logic [NREQ-1:0][WIDTH-1:0] reqB;
    logic [NREQ-1:0][3:0]       reqCtrl;
    logic [NREQ-1:0]            rspValid;
    logic [NREQ-1:0]            rspReady;
    logic [WIDTH-1:0]           rspResult;
    logic                       rspZero;
    logic                       rspLess;
    logic                       rspErr;

    modport master (
        output reqValid, reqA, reqB, reqCtrl, rspReady,
        input  reqReady, rspValid, rspResult, rspZero, rspLess, rspErr
    );

    modport slave (
        input  reqValid, reqA, reqB, reqCtrl, rspReady,
        output reqReady, rspValid, rspResult, rspZero, rspLess, rspErr
    );

endinterface

// File: rtl/ALU.sv
// Purely combinational ALU. Shift amounts use only the low log2(WIDTH) bits
// of b; illegal op codes produce err=1 with a zero result.
module ALU
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             less_o,
    output logic             err_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        less_o   = 1'b0;
        err_o    = !is_legal_op(ctrl_i);
        case (ctrl_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT: begin
                less_o   = $signed(a_i) < $signed(b_i);
                result_o = {{(WIDTH-1){1'b0}}, less_o};
            end
            ALU_SLTU: begin
                less_o   = a_i < b_i;
                result_o = {{(WIDTH-1){1'b0}}, less_o};
            end
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU, one op in flight.
// Define ALU_ARB_FAIR_EN for round-robin grants; otherwise port 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       ctrl_q;
    logic             id_q;
    logic [WIDTH-1:0] res_q;
    logic             less_q, err_q, have_res_q;

    logic             gnt;
    logic             accept;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_less, alu_err;

`ifdef ALU_ARB_FAIR_EN
    logic ptr_q;

    // Contention goes to the pointer; a lone requester always wins.
    assign gnt = (&bus.reqValid) ? ptr_q : bus.reqValid[1];
`else
    assign gnt = ~bus.reqValid[0];
`endif

    // Gated by rst_n so no handshake is reported while reset is held.
    assign accept = rst_n && (state_q == ST_IDLE) && (|bus.reqValid);

    always_comb begin
        bus.reqReady = '0;
        if (accept) bus.reqReady[gnt] = 1'b1;
    end

    always_comb begin
        bus.rspValid = '0;
        if (state_q == ST_RESP) bus.rspValid[id_q] = 1'b1;
    end

    assign bus.rspResult = res_q;
    assign bus.rspLess   = less_q;
    assign bus.rspErr    = err_q;
    assign bus.rspZero   = have_res_q && (res_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rspReady[id_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_b = is_shift_op(ctrl_q) ? {{(WIDTH-SHW){1'b0}}, b_q[SHW-1:0]} : b_q;

    ALU #(.WIDTH(WIDTH)) u_alu (
        .a_i      (a_q),
        .b_i      (alu_b),
        .ctrl_i   (ctrl_q),
        .result_o (alu_res),
        .less_o   (alu_less),
        .err_o    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            id_q       <= 1'b0;
            res_q      <= '0;
            less_q     <= 1'b0;
            err_q      <= 1'b0;
            have_res_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= bus.reqA[gnt];
                b_q    <= bus.reqB[gnt];
                ctrl_q <= bus.reqCtrl[gnt];
                id_q   <= gnt;
            end
            if (state_q == ST_EXEC) begin
                res_q      <= alu_res;
                less_q     <= alu_less;
                err_q      <= alu_err;
                have_res_q <= 1'b1;
            end
        end
    end

`ifdef ALU_ARB_FAIR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)      ptr_q <= 1'b0;
        else if (accept) ptr_q <= ~gnt;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: op results, latency, arbitration order,
// response backpressure and reset while an op is in flight.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) bus ();
    alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nvec = 0;
    int nerr = 0;
    int exp_gnt [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.reqA[p]    = a;
        bus.reqB[p]    = b;
        bus.reqCtrl[p] = c;
    endtask

    // Starts and ends at a falling edge; checks accept, EXEC gap, response and return to idle.
    task automatic do_op(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic [31:0] er, input logic ez,
                         input logic el, input logic ee);
        set_req(p, a, b, c);
        bus.reqValid    = '0;
        bus.reqValid[p] = 1'b1;
        bus.rspReady    = 2'b11;
        #1 chk({tag, ".reqReady"}, 32'(bus.reqReady), 32'(1 << p));
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = '0;
        chk({tag, ".execValid"}, 32'(bus.rspValid), 32'd0);
        @(negedge clk);
        chk({tag, ".rspValid"}, 32'(bus.rspValid), 32'(1 << p));
        chk({tag, ".result"}, bus.rspResult, er);
        chk({tag, ".zero"}, 32'(bus.rspZero), 32'(ez));
        chk({tag, ".less"}, 32'(bus.rspLess), 32'(el));
        chk({tag, ".err"}, 32'(bus.rspErr), 32'(ee));
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".idle"}, 32'(bus.rspValid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.reqValid = 2'b11;
        bus.rspReady = 2'b00;
        set_req(0, 32'd0, 32'd0, ALU_ADD);
        set_req(1, 32'd0, 32'd0, ALU_ADD);
        repeat (2) @(negedge clk);
        chk("rst.reqReady", 32'(bus.reqReady), 32'd0);
        chk("rst.rspValid", 32'(bus.rspValid), 32'd0);
        chk("rst.result", bus.rspResult, 32'd0);
        chk("rst.zero", 32'(bus.rspZero), 32'd0);
        chk("rst.less", 32'(bus.rspLess), 32'd0);
        chk("rst.err", 32'(bus.rspErr), 32'd0);
        bus.reqValid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op("slt",  1, 32'hFFFF_FFFE, 32'd3, ALU_SLT,  32'd1, 1'b0, 1'b1, 1'b0);
        do_op("sltu", 1, 32'hFFFF_FFFE, 32'd3, ALU_SLTU, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op("sra",  0, 32'h8000_0000, 32'h24, ALU_SRA, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        do_op("srl",  0, 32'h8000_0000, 32'h24, ALU_SRL, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        do_op("sll",  1, 32'd1, 32'h21, ALU_SLL, 32'd2, 1'b0, 1'b0, 1'b0);
        do_op("sub",  1, 32'd3, 32'd5, ALU_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op("and",  0, 32'hF0F0_1234, 32'h0FF0_FF00, ALU_AND, 32'h00F0_1200, 1'b0, 1'b0, 1'b0);
        do_op("or",   0, 32'hF000_0000, 32'h0000_000F, ALU_OR, 32'hF000_000F, 1'b0, 1'b0, 1'b0);
        do_op("illegal", 0, 32'd7, 32'd9, 4'b0101, 32'd0, 1'b1, 1'b0, 1'b1);

        // Both ports requesting continuously for four grants
`ifdef ALU_ARB_FAIR_EN
        exp_gnt = '{0, 1, 0, 1};
`else
        exp_gnt = '{0, 0, 0, 0};
`endif
        do_reset();
        set_req(0, 32'd1, 32'd2, ALU_ADD);
        set_req(1, 32'd10, 32'd3, ALU_SUB);
        bus.reqValid = 2'b11;
        bus.rspReady = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("arb%0d.reqReady", k), 32'(bus.reqReady), 32'(1 << exp_gnt[k]));
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("arb%0d.rspValid", k), 32'(bus.rspValid), 32'(1 << exp_gnt[k]));
            chk($sformatf("arb%0d.result", k), bus.rspResult, (exp_gnt[k] == 1) ? 32'd7 : 32'd3);
            @(posedge clk);
            @(negedge clk);
        end
        bus.reqValid = '0;
        @(negedge clk);

        // Backpressure on port 0 while port 1 waits and toggles its own rspReady
        set_req(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_XOR);
        set_req(1, 32'd5, 32'd6, ALU_ADD);
        bus.reqValid = 2'b01;
        bus.rspReady = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.rspValid", i), 32'(bus.rspValid), 32'd1);
            chk($sformatf("bp%0d.result", i), bus.rspResult, 32'hFF00_FF00);
            chk($sformatf("bp%0d.reqReady", i), 32'(bus.reqReady), 32'd0);
            bus.rspReady[1] = ~bus.rspReady[1];
            @(negedge clk);
        end
        bus.rspReady = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("bp.release.reqReady", 32'(bus.reqReady), 32'd2);
        chk("bp.release.rspValid", 32'(bus.rspValid), 32'd0);
        bus.reqValid = '0;
        @(negedge clk);

        // Reset asserted while an op is in EXEC
        set_req(0, 32'd7, 32'd8, ALU_ADD);
        bus.reqValid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rexec.rspValid", 32'(bus.rspValid), 32'd0);
        chk("rexec.result", bus.rspResult, 32'd0);
        chk("rexec.zero", 32'(bus.rspZero), 32'd0);
        chk("rexec.less", 32'(bus.rspLess), 32'd0);
        chk("rexec.err", 32'(bus.rspErr), 32'd0);
        chk("rexec.reqReady", 32'(bus.reqReady), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rexec.noResp", 32'(bus.rspValid), 32'd0);
        do_op("after_rst", 0, 32'd7, 32'd8, ALU_ADD, 32'd15, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
